// File: rtl/pc_unit_pkg.sv
// Shared constants for the PC stage: next-PC select codes, FSM states and
// the default reset / instruction-memory window addresses.
package pc_unit_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

endpackage

// File: rtl/pc_unit_npc_calc.sv
// Combinational next-PC target selection and fetch-address legality check.
module npc_calc
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] IMEM_LO = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI = DEF_IMEM_HI
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        br_cond,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] rs_val,
    output logic [31:0] npc,
    output logic        npc_legal
);

    logic [31:0] seq_pc;

    always_comb begin
        seq_pc = pc + 32'd4;
        npc    = seq_pc;
        case (npc_op)
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = br_cond ? (seq_pc + br_offset) : seq_pc;
            NPC_J:   npc = {seq_pc[31:28], j_index, 2'b00};
            NPC_JR:  npc = rs_val;
            default: npc = seq_pc;
        endcase
    end

    // Wrapped branch targets land outside the window, so no separate overflow case.
    always_comb begin
        npc_legal = (npc[1:0] == 2'b00) && (npc >= IMEM_LO) && (npc <= IMEM_HI);
    end

endmodule

// File: rtl/pc_unit.sv
// PC register, RUN/HALT fetch-error FSM and accepted-update counter for the
// single-cycle MIPS datapath.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  npc_op,
    input  logic        br_cond,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        addr_err,
    output logic [31:0] err_pc,
    output logic [31:0] upd_cnt
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic [31:0] upd_cnt_q, upd_cnt_d;

    logic [31:0] npc;
    logic        npc_legal;

    npc_calc #(
        .IMEM_LO (IMEM_LO),
        .IMEM_HI (IMEM_HI)
    ) u_npc_calc (
        .pc        (pc_q),
        .npc_op    (npc_op),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .j_index   (j_index),
        .rs_val    (rs_val),
        .npc       (npc),
        .npc_legal (npc_legal)
    );

    // A stalled cycle never evaluates legality; HALT freezes everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        err_pc_d   = err_pc_q;
        upd_cnt_d  = upd_cnt_q;
        if (state_q == ST_RUN && en) begin
            if (npc_legal) begin
                pc_d      = npc;
                upd_cnt_d = upd_cnt_q + 32'd1;
            end else begin
                addr_err_d = 1'b1;
                err_pc_d   = npc;
                state_d    = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
            err_pc_q   <= 32'd0;
            upd_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
            err_pc_q   <= err_pc_d;
            upd_cnt_q  <= upd_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign link_addr = pc_q + 32'd4;
    assign addr_err  = addr_err_q;
    assign err_pc    = err_pc_q;
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized check of pc_unit against an arithmetic reference model.
module tb_pc_unit;

    localparam logic [31:0] LO  = 32'h0000_3000;
    localparam logic [31:0] HI  = 32'h0000_6FFC;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br_cond = 1'b0;
    logic [31:0] br_offset = 32'd0;
    logic [25:0] j_index = 26'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] pc, pc_plus4, link_addr, err_pc, upd_cnt;
    logic        addr_err;

    pc_unit #(.RESET_PC(RPC), .IMEM_LO(LO), .IMEM_HI(HI)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .npc_op    (npc_op),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .j_index   (j_index),
        .rs_val    (rs_val),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .link_addr (link_addr),
        .addr_err  (addr_err),
        .err_pc    (err_pc),
        .upd_cnt   (upd_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] m_err_pc = 32'd0;
    logic        m_err = 1'b0;
    logic        m_halt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".upd_cnt"}, upd_cnt, m_cnt);
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
        chk({tag, ".err_pc"}, err_pc, m_err_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".link_addr"}, link_addr, m_pc + 32'd4);
        $display("%s: pc=%h cnt=%0d err=%0b err_pc=%h", tag, pc, upd_cnt, addr_err, err_pc);
    endtask

    // One clock: drive inputs, advance the model by the rules, then compare.
    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] op,
                        input logic c, input logic [31:0] off, input logic [25:0] ji,
                        input logic [31:0] rs);
        logic [31:0] seq, cand;
        reset = r; en = e; npc_op = op; br_cond = c; br_offset = off; j_index = ji; rs_val = rs;
        seq = m_pc + 32'd4;
        case (op)
            2'd1:    cand = c ? seq + off : seq;
            2'd2:    cand = {seq[31:28], ji, 2'b00};
            2'd3:    cand = rs;
            default: cand = seq;
        endcase
        @(posedge clk);
        if (r) begin
            m_pc = RPC; m_cnt = 0; m_err = 0; m_err_pc = 0; m_halt = 0;
        end else if (!m_halt && e) begin
            if (cand % 4 == 0 && cand >= LO && cand <= HI) begin
                m_pc = cand; m_cnt = m_cnt + 1;
            end else begin
                m_err = 1; m_err_pc = cand; m_halt = 1;
            end
        end
        #1;
        // Mid-cycle glitch on the selects must not matter.
        npc_op = ~op; rs_val = ~rs; br_cond = ~c;
        check_all(tag);
    endtask

    task automatic rst(input string tag);
        step(tag, 1'b1, 1'b1, 2'd3, 1'b1, 32'd0, 26'd0, 32'd1);
    endtask

    task automatic jr(input string tag, input logic [31:0] rs);
        step(tag, 1'b0, 1'b1, 2'd3, 1'b0, 32'd0, 26'd0, rs);
    endtask

    task automatic seq1(input string tag);
        step(tag, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0);
    endtask

    initial begin
        logic        r, e, c;
        logic [1:0]  op;
        logic [31:0] off, rs;
        logic [25:0] ji;

        @(negedge clk);
        rst("reset");
        seq1("seq1"); seq1("seq2"); seq1("seq3");
        seq1("seq4");
        step("br_taken", 1'b0, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFF8, 26'd0, 32'd0);
        seq1("seq5");
        step("br_not", 1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFF8, 26'd0, 32'd0);
        jr("jr_3020", 32'h3020);
        step("j", 1'b0, 1'b1, 2'd2, 1'b0, 32'd0, 26'h0000C40, 32'd0);
        jr("jr_3024", 32'h3024);
        for (int i = 0; i < 4; i++)
            step("stall", 1'b0, 1'b0, 2'd3, 1'b0, 32'd0, 26'd0, 32'h1);
        rst("reset2");
        jr("jr_misalign", 32'h3002);
        for (int i = 0; i < 5; i++) seq1("halt_seq");
        rst("reset_halt");
        jr("jr_hi", 32'h6FFC);
        jr("jr_above", 32'h7000);
        rst("reset3");
        jr("jr_below", 32'h2FFC);
        rst("reset4");

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < (m_halt ? 20 : 2));
            e  = ($urandom_range(0, 99) < 80);
            op = 2'($urandom_range(0, 3));
            c  = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 15) == 0) ? $urandom
                  : 32'($urandom_range(0, 127)) * 32'd4 - 32'd256;
            ji = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                 : 26'($urandom_range(32'h0C00, 32'h1BFF));
            rs = ($urandom_range(0, 5) == 0) ? $urandom
                 : LO + 32'($urandom_range(0, 32'hFFF)) * 32'd4;
            step("rand", r, e, op, c, off, ji, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS datapath.
- Holds the PC register and selects the next PC: sequential, branch, jump or register jump.
- Consumes the branch offset produced by the shift-by-2 stage, which is already sign-extended and shifted left by 2.
- Drives the instruction-memory address and the link address.
- Halts on an illegal fetch target and keeps a count of accepted PC updates.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  PC write enable; 0 = stall (hold all state).
- npc_op  in  2  next-PC select: 00 SEQ, 01 BR, 10 J, 11 JR.
- br_cond  in  1  branch comparator result; used only when npc_op = BR.
- br_offset  in  32  sign-extended immediate already shifted left by 2.
- j_index  in  26  instr_index field of J/JAL.
- rs_val  in  32  GPR[rs] for JR.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc + 4 (combinational).
- link_addr  out  32  return address for JAL; equals pc + 4 (no delay slot).
- addr_err  out  1  sticky illegal-target flag (registered).
- err_pc  out  32  offending next-PC value, captured when addr_err sets.
- upd_cnt  out  32  count of accepted PC updates (registered).

## Operation

Candidate next PC (combinational), all arithmetic modulo 2^32:
- SEQ: pc + 4.
- BR: pc + 4 + br_offset if br_cond = 1, else pc + 4.
- J: {pc_plus4[31:28], j_index, 2'b00}.
- JR: rs_val.

Legality of a candidate:
- npc[1:0] must be 2'b00.
- IMEM_LO <= npc <= IMEM_HI, compared unsigned.

State machine, two states:
- RUN:
  - en = 0: hold everything.
  - en = 1, candidate legal: pc <= npc, upd_cnt <= upd_cnt + 1; stay in RUN.
  - en = 1, candidate illegal: pc holds, addr_err <= 1, err_pc <= npc, upd_cnt holds; go to HALT.
- HALT:
  - pc, upd_cnt, addr_err and err_pc all hold regardless of en or npc_op.
  - Only reset leaves HALT.

Other rules:
- The legality check runs only when en = 1 in RUN. A stalled illegal candidate raises no error.
- upd_cnt wraps from 32'hFFFF_FFFF to 0.

## Timing

- Reset has priority over every other input on the same edge. It gives pc = RESET_PC, addr_err = 0, err_pc = 0, upd_cnt = 0, state = RUN.
  - Reset asserted mid-stall or in HALT gives the same result.
- pc_plus4, link_addr and the candidate npc are combinational from pc and the inputs.
- pc, addr_err, err_pc and upd_cnt change only on rising edges. Latency from input to pc is 1 cycle.
- An illegal candidate shows addr_err = 1 and err_pc valid in the cycle after the offending edge, while pc still shows the last legal value.
- npc_op values, br_cond, br_offset, j_index and rs_val are sampled only at the edge. Input glitches mid-cycle have no effect.
- A backward branch crossing below IMEM_LO, or a forward branch wrapping past 2^32, is caught by the range check. It is not a separate case.

## Structure

Shared package (e.g. mips_defs):
- NPC_SEQ / NPC_BR / NPC_J / NPC_JR 2-bit encodings.
- State encodings ST_RUN / ST_HALT.
- Default RESET_PC, IMEM_LO and IMEM_HI constants.

One sub-module, npc_calc: purely combinational target selection plus the legality check.
- Inputs: pc, npc_op, br_cond, br_offset, j_index, rs_val.
- Outputs: npc, npc_legal.
- pc_unit holds the registers, the FSM and the counter.

## Test plan

- Reset then 3 cycles of SEQ with en = 1 -> pc 0x3000, 0x3004, 0x3008, 0x300C; upd_cnt = 3; link_addr = pc + 4 each cycle.
- pc = 0x3010, BR with br_offset = 0xFFFF_FFF8:
  - br_cond = 1 -> pc = 0x300C.
  - br_cond = 0 -> pc = 0x3014.
- pc = 0x3020, J with j_index = 26'h0000C40 -> pc = 0x3100. pc = 0x3100, JR with rs_val = 0x3024 -> pc = 0x3024.
- Stall: en = 0 for 4 cycles with npc_op = JR and rs_val = 0x0000_0001 (illegal) -> pc, upd_cnt unchanged; addr_err stays 0.
- pc = 0x3000, en = 1, JR with rs_val = 0x3002 -> next cycle addr_err = 1, err_pc = 0x3002, pc = 0x3000. Then 5 cycles of SEQ -> all outputs frozen. Then reset -> pc = 0x3000, addr_err = 0, upd_cnt = 0.
- Range edges: JR with rs_val = 0x6FFC -> accepted. JR 0x7000 -> error. JR 0x2FFC from a fresh reset -> error.
